// File: rtl/llc_cmd_dispatch.sv
// LLC trace command front end: in-order command FIFO, address decode, one-at-a-time cache request issue, clear/print sequencing.
// Latency: a command accepted into an empty FIFO with the FSM idle is popped on the next edge, so req_valid rises two edges after it is presented.
// Backpressure: cmd_ready = FIFO not full (no pass-through when full); req_* held stable until req_ready; clear/print wait for their done pulses.
module llc_cmd_dispatch #(
    parameter  int ADDR_SIZE   = 32,
    parameter  int OFFSET_SIZE = 6,
    parameter  int INDEX_SIZE  = 14,
    parameter  int FIFO_DEPTH  = 8,
    localparam int TAG_SIZE    = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_code,
    input  logic [ADDR_SIZE-1:0]   cmd_addr,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [3:0]             req_code,
    output logic                   req_snoop,
    output logic [TAG_SIZE-1:0]    req_tag,
    output logic [INDEX_SIZE-1:0]  req_index,
    output logic [OFFSET_SIZE-1:0] req_offset,
    output logic                   clear_start,
    input  logic                   clear_done,
    output logic                   print_req,
    input  logic                   print_done,
    output logic                   busy,
    output logic                   err_illegal,
    output logic [15:0]            illegal_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ISSUE      = 3'd1;
    localparam logic [2:0] ST_CLEAR_REQ  = 3'd2;
    localparam logic [2:0] ST_CLEAR_WAIT = 3'd3;
    localparam logic [2:0] ST_PRINT_WAIT = 3'd4;

    typedef struct packed {
        logic [3:0]           code;
        logic [ADDR_SIZE-1:0] addr;
    } cmd_t;

    // FIFO storage; pointers carry an extra wrap bit to tell full from empty
    cmd_t           mem_q [FIFO_DEPTH];
    cmd_t           mem_d [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           fifo_empty, fifo_full;
    cmd_t           head;

    logic [2:0]             state_q, state_d;
    logic [3:0]             req_code_q, req_code_d;
    logic                   req_snoop_q, req_snoop_d;
    logic [TAG_SIZE-1:0]    req_tag_q, req_tag_d;
    logic [INDEX_SIZE-1:0]  req_index_q, req_index_d;
    logic [OFFSET_SIZE-1:0] req_offset_q, req_offset_d;
    logic                   err_illegal_q, err_illegal_d;
    logic [15:0]            illegal_cnt_q, illegal_cnt_d;

    logic cmd_legal, cmd_fire, push, pop, illegal_fire;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Ready is withheld while reset is asserted so every output reads 0 in reset
    assign cmd_ready    = !fifo_full && !rst;
    assign cmd_legal    = (cmd_code <= 4'd6) || (cmd_code == 4'd8) || (cmd_code == 4'd9);
    assign cmd_fire     = cmd_valid && cmd_ready;
    assign push         = cmd_fire && cmd_legal;
    assign illegal_fire = cmd_fire && !cmd_legal;

    // FIFO write/read pointer and storage update
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]].code = cmd_code;
            mem_d[wr_ptr_q[PTR_W-1:0]].addr = cmd_addr;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Illegal codes are consumed but only counted and flagged
    always_comb begin
        err_illegal_d = illegal_fire;
        illegal_cnt_d = illegal_cnt_q;
        if (illegal_fire && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    // Dispatch FSM: pop only from IDLE so nothing overlaps a pending request, clear or print
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        req_code_d   = req_code_q;
        req_snoop_d  = req_snoop_q;
        req_tag_d    = req_tag_q;
        req_index_d  = req_index_q;
        req_offset_d = req_offset_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.code <= 4'd6) begin
                        state_d      = ST_ISSUE;
                        req_code_d   = head.code;
                        req_snoop_d  = (head.code >= 4'd3);
                        req_tag_d    = head.addr[ADDR_SIZE-1 -: TAG_SIZE];
                        req_index_d  = head.addr[OFFSET_SIZE +: INDEX_SIZE];
                        req_offset_d = head.addr[OFFSET_SIZE-1:0];
                    end else if (head.code == 4'd8) begin
                        state_d = ST_CLEAR_REQ;
                    end else if (head.code == 4'd9) begin
                        state_d = ST_PRINT_WAIT;
                    end
                end
            end
            ST_ISSUE: begin
                if (req_ready) state_d = ST_IDLE;
            end
            ST_CLEAR_REQ: begin
                // clear_done arriving here belongs to nothing we asked for yet
                state_d = ST_CLEAR_WAIT;
            end
            ST_CLEAR_WAIT: begin
                if (clear_done) state_d = ST_IDLE;
            end
            ST_PRINT_WAIT: begin
                if (print_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons all in-flight work and empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            state_q       <= ST_IDLE;
            req_code_q    <= '0;
            req_snoop_q   <= 1'b0;
            req_tag_q     <= '0;
            req_index_q   <= '0;
            req_offset_q  <= '0;
            err_illegal_q <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            state_q       <= state_d;
            req_code_q    <= req_code_d;
            req_snoop_q   <= req_snoop_d;
            req_tag_q     <= req_tag_d;
            req_index_q   <= req_index_d;
            req_offset_q  <= req_offset_d;
            err_illegal_q <= err_illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // Handshake outputs decode straight from the state flop so reset drops them at once
    assign req_valid   = (state_q == ST_ISSUE);
    assign clear_start = (state_q == ST_CLEAR_REQ);
    assign print_req   = (state_q == ST_PRINT_WAIT);
    assign busy        = !fifo_empty || (state_q != ST_IDLE);
    assign req_code    = req_code_q;
    assign req_snoop   = req_snoop_q;
    assign req_tag     = req_tag_q;
    assign req_index   = req_index_q;
    assign req_offset  = req_offset_q;
    assign err_illegal = err_illegal_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_llc_cmd_dispatch.sv
module tb_llc_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_code;
    logic [31:0] cmd_addr;
    logic        req_valid, req_ready;
    logic [3:0]  req_code;
    logic        req_snoop;
    logic [11:0] req_tag;
    logic [13:0] req_index;
    logic [5:0]  req_offset;
    logic        clear_start, clear_done, print_req, print_done, busy, err_illegal;
    logic [15:0] illegal_cnt;

    int checks = 0;
    int errors = 0;

    llc_cmd_dispatch dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_addr(cmd_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code), .req_snoop(req_snoop),
        .req_tag(req_tag), .req_index(req_index), .req_offset(req_offset),
        .clear_start(clear_start), .clear_done(clear_done),
        .print_req(print_req), .print_done(print_done),
        .busy(busy), .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    // Packs the request outputs as {code, snoop, tag, index, offset}
    function automatic logic [36:0] exp_req(input logic [3:0] code, input logic [31:0] a);
        exp_req = {code, (code >= 4'd3 && code <= 4'd6), a[31:20], a[19:6], a[5:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_addr = '0;
        req_ready = 1'b0; clear_done = 1'b0; print_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_valid, clear_start, print_req, busy, err_illegal, cmd_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {req_valid, clear_start, print_req, busy, err_illegal, cmd_ready});
        end
        checks++;
        if ({illegal_cnt, req_code, req_snoop, req_tag, req_index, req_offset} !== 53'd0) begin
            errors++;
            $display("FAIL reset_data: cnt %h code %h tag %h idx %h off %h expected all 0",
                     illegal_cnt, req_code, req_tag, req_index, req_offset);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready %b busy %b expected 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic();
        req_ready = 1'b1;
        cmd_valid = 1'b1; cmd_code = 4'd0; cmd_addr = 32'h0000_1040;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (req_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_edge1: req_valid %b busy %b expected 0 1", req_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: req_valid %b expected 1", req_valid);
        end
        checks++;
        if ({req_code, req_snoop, req_tag, req_index, req_offset} !== {4'h0, 1'b0, 12'h000, 14'h0041, 6'h00}) begin
            errors++;
            $display("FAIL basic_fields: code %h snoop %b tag %h idx %h off %h expected 0 0 000 0041 00",
                     req_code, req_snoop, req_tag, req_index, req_offset);
        end
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: req_valid %b busy %b expected 0 0", req_valid, busy);
        end
    endtask

    task automatic test_fill();
        logic [3:0]  codes [9];
        logic [31:0] addrs [9];
        logic [36:0] exp_v;
        int k = 0;
        int n = 0;
        int unstable = 0;
        bit stop = 1'b0;
        for (int i = 0; i < 9; i++) begin
            codes[i] = 4'(i % 7);
            addrs[i] = 32'h1234_5678 + 32'(i) * 32'h0101_0041;
        end
        req_ready = 1'b0;
        // One command is held in the request register, eight fill the FIFO
        for (int c = 0; c < 20 && !stop; c++) begin
            if (cmd_ready && k < 9) begin
                cmd_valid = 1'b1; cmd_code = codes[k]; cmd_addr = addrs[k]; k++;
                @(negedge clk);
            end else begin
                cmd_valid = 1'b0; stop = 1'b1;
            end
        end
        checks++;
        if (k !== 9 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: accepted %0d cmd_ready %b expected 9 0", k, cmd_ready);
        end
        exp_v = exp_req(codes[0], addrs[0]);
        cmd_valid = 1'b1; cmd_code = 4'd1; cmd_addr = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || req_valid !== 1'b1 ||
                {req_code, req_snoop, req_tag, req_index, req_offset} !== exp_v) unstable++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL fill_stall_stable: %0d bad stall cycles expected 0", unstable);
        end
        req_ready = 1'b1;
        for (int c = 0; c < 60 && n < 9; c++) begin
            if (req_valid) begin
                exp_v = exp_req(codes[n], addrs[n]);
                checks++;
                if ({req_code, req_snoop, req_tag, req_index, req_offset} !== exp_v) begin
                    errors++;
                    $display("FAIL fill_order[%0d]: got %h expected %h", n,
                             {req_code, req_snoop, req_tag, req_index, req_offset}, exp_v);
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n !== 9 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_drain: issued %0d busy %b expected 9 0", n, busy);
        end
    endtask

    task automatic test_illegal();
        int issued = 0;
        cmd_valid = 1'b1; cmd_code = 4'd7; cmd_addr = 32'h0000_0100;
        @(negedge clk);
        cmd_code = 4'd15;
        checks++;
        if (err_illegal !== 1'b1 || illegal_cnt !== 16'd1) begin
            errors++;
            $display("FAIL illegal_first: err %b cnt %0d expected 1 1", err_illegal, illegal_cnt);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (err_illegal !== 1'b1 || illegal_cnt !== 16'd2) begin
            errors++;
            $display("FAIL illegal_second: err %b cnt %0d expected 1 2", err_illegal, illegal_cnt);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (req_valid || busy || err_illegal) issued++;
        end
        checks++;
        if (issued !== 0 || illegal_cnt !== 16'd2) begin
            errors++;
            $display("FAIL illegal_dropped: %0d active cycles cnt %0d expected 0 2", issued, illegal_cnt);
        end
        cmd_valid = 1'b1; cmd_code = 4'd10;
        repeat (65533) @(negedge clk);
        checks++;
        if (illegal_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL illegal_reach_max: cnt %h expected ffff", illegal_cnt);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (illegal_cnt !== 16'hFFFF || err_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_saturate: cnt %h err %b expected ffff 1", illegal_cnt, err_illegal);
        end
        @(negedge clk);
    endtask

    task automatic test_snoop_clear();
        int bad = 0;
        int c = 0;
        req_ready = 1'b0;
        cmd_valid = 1'b1; cmd_code = 4'd3; cmd_addr = 32'hFFFF_8000;
        @(negedge clk);
        cmd_code = 4'd8; cmd_addr = 32'h0;
        @(negedge clk);
        cmd_code = 4'd1; cmd_addr = 32'h0000_2000;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (req_valid !== 1'b1 || clear_start !== 1'b0 ||
            {req_code, req_snoop, req_tag, req_index, req_offset} !== {4'h3, 1'b1, 12'hFFF, 14'h3E00, 6'h00}) begin
            errors++;
            $display("FAIL snoop_fields: vld %b clr %b code %h snoop %b tag %h idx %h off %h expected 1 0 3 1 fff 3e00 00",
                     req_valid, clear_start, req_code, req_snoop, req_tag, req_index, req_offset);
        end
        req_ready = 1'b1;
        while (c < 10 && clear_start !== 1'b1) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (clear_start !== 1'b1) begin
            errors++;
            $display("FAIL clear_start_seen: clear_start %b expected 1", clear_start);
        end
        clear_done = 1'b1;  // arrives while still in the request cycle: must be ignored
        @(negedge clk);
        clear_done = 1'b0;
        checks++;
        if (clear_start !== 1'b0 || req_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_pulse: clear_start %b req_valid %b busy %b expected 0 0 1",
                     clear_start, req_valid, busy);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_valid || clear_start) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL clear_withhold: %0d early cycles expected 0", bad);
        end
        clear_done = 1'b1;
        @(negedge clk);
        clear_done = 1'b0;
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b1 ||
            {req_code, req_snoop, req_tag, req_index, req_offset} !== {4'h1, 1'b0, 12'h000, 14'h0080, 6'h00}) begin
            errors++;
            $display("FAIL clear_then_req: vld %b code %h snoop %b tag %h idx %h off %h expected 1 1 0 000 0080 00",
                     req_valid, req_code, req_snoop, req_tag, req_index, req_offset);
        end
        @(negedge clk);
    endtask

    task automatic test_print();
        int bad = 0;
        req_ready = 1'b1;
        cmd_valid = 1'b1; cmd_code = 4'd9; cmd_addr = 32'h0;
        @(negedge clk);
        cmd_code = 4'd2; cmd_addr = 32'h0ABC_DE3F;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (print_req !== 1'b1) begin
            errors++;
            $display("FAIL print_start: print_req %b expected 1", print_req);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (print_req !== 1'b1 || req_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL print_hold: %0d bad cycles expected 0", bad);
        end
        print_done = 1'b1;
        @(negedge clk);
        print_done = 1'b0;
        checks++;
        if (print_req !== 1'b0 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL print_drop: print_req %b req_valid %b expected 0 0", print_req, req_valid);
        end
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b1 ||
            {req_code, req_snoop, req_tag, req_index, req_offset} !== {4'h2, 1'b0, 12'h0AB, 14'h3378, 6'h3F}) begin
            errors++;
            $display("FAIL print_then_req: vld %b code %h snoop %b tag %h idx %h off %h expected 1 2 0 0ab 3378 3f",
                     req_valid, req_code, req_snoop, req_tag, req_index, req_offset);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL print_idle: busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_code = 4'(i); cmd_addr = 32'h0000_4000 + 32'(i * 64);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (req_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: req_valid %b busy %b expected 1 1", req_valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (req_valid !== 1'b0 || busy !== 1'b0 || clear_start !== 1'b0 || print_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: req_valid %b busy %b clr %b prt %b expected 0 0 0 0",
                     req_valid, busy, clear_start, print_req);
        end
        @(negedge clk);
        rst = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || illegal_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_release: busy %b cmd_ready %b cnt %0d expected 0 1 0", busy, cmd_ready, illegal_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req_valid || busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midrst_flushed: %0d active cycles expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_illegal();
        test_snoop_clear();
        test_print();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
